// File: rtl/disp_pkg.sv
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared types and constants for the display source arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } disp_state_t;

    localparam int DEF_NUM_SRC   = 4;
    localparam int DEF_DWELL_CYC = 50000000;
    localparam int DEF_CNT_W     = 26;

    // Short dwell used by simulation benches
    localparam int DWELL_SIM     = 4;

    // Width of a source index as presented on disp_src
    localparam int SRC_IDX_W     = 4;

endpackage

`default_nettype wire

// File: rtl/disp_rr_pick.sv
// ============================================================================
// Module   : disp_rr_pick
// Brief    : Combinational round-robin picker. Returns the first requester
//            strictly after the pointer, wrapping around to the pointer
//            itself last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_rr_pick
    import disp_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic [NUM_SRC-1:0]   winner,
    output logic [SRC_IDX_W-1:0] win_idx,
    output logic                 any_req
);

    logic [NUM_SRC-1:0] above;
    logic               found;

    // Prefer requesters above the pointer; otherwise take the lowest requester
    always_comb begin
        above   = '0;
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        any_req = |req;
        for (int i = 0; i < NUM_SRC; i++) begin
            above[i] = (i > int'(ptr)) && req[i];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && above[i]) begin
                found     = 1'b1;
                winner[i] = 1'b1;
                win_idx   = SRC_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                winner[i] = 1'b1;
                win_idx   = SRC_IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_src_arbiter.sv
// ============================================================================
// Module   : disp_src_arbiter
// Brief    : Time-shares the seven-segment display between debug sources,
//            round-robin with a fixed dwell, manual advance and freeze.
//            Build option DISP_SRC_TAG_EN puts the source index into
//            disp_data[31:28].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_src_arbiter
    import disp_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int DWELL_CYC = DEF_DWELL_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                    fpga_clk,
    input  logic                    fpga_rst,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [NUM_SRC*32-1:0]   src_data,
    input  logic                    next_pls,
    input  logic                    hold,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    grant_valid,
    output logic [SRC_IDX_W-1:0]    disp_src,
    output logic [31:0]             disp_data
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYC - 1);

    disp_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [SRC_IDX_W-1:0]   ptr;

    logic [NUM_SRC-1:0]     pick_oh;
    logic [SRC_IDX_W-1:0]   pick_idx;
    logic                   pick_any;
    logic [31:0]            cur_word;
    logic [31:0]            show_word;
    logic                   cur_req;
    logic                   trigger;

    // The pointer always holds the last winner, so the pick is "next after it"
    disp_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req     (src_req),
        .ptr     (ptr),
        .winner  (pick_oh),
        .win_idx (pick_idx),
        .any_req (pick_any)
    );

    // Select the word of the currently granted source via the one-hot grant
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                cur_word = src_data[i*32 +: 32];
            end
        end
    end

    // Optionally overlay the source index on the leftmost digit
    always_comb begin
        show_word = cur_word;
`ifdef DISP_SRC_TAG_EN
        show_word[31:28] = disp_src;
`endif
    end

    assign cur_req = |(src_req & grant);
    // Expiry and next_pls collapse into one trigger, so they advance only once
    assign trigger = (cnt == '0) || next_pls || !cur_req;

    // Arbitration state machine with registered outputs
    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            disp_src    <= '0;
            disp_data   <= '0;
            cnt         <= '0;
            ptr         <= SRC_IDX_W'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= SHOW;
                        grant       <= pick_oh;
                        disp_src    <= pick_idx;
                        grant_valid <= 1'b1;
                        cnt         <= CNT_LOAD;
                        ptr         <= pick_idx;
                    end
                end
                SHOW: begin
                    if (hold) begin
                        state <= HOLD;
                    end else begin
                        disp_data <= show_word;
                        if (trigger) begin
                            if (pick_any) begin
                                grant    <= pick_oh;
                                disp_src <= pick_idx;
                                cnt      <= CNT_LOAD;
                                ptr      <= pick_idx;
                            end else begin
                                state       <= IDLE;
                                grant       <= '0;
                                grant_valid <= 1'b0;
                                disp_src    <= '0;
                                disp_data   <= '0;
                                cnt         <= '0;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Everything stays frozen; any pending trigger is seen in SHOW
                    if (!hold) begin
                        state <= SHOW;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_disp_src_arbiter.sv
// ============================================================================
// Module   : tb_disp_src_arbiter
// Brief    : Self-checking bench for disp_src_arbiter (DWELL_CYC = 4).
//            Honours DISP_SRC_TAG_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_src_arbiter;
    import disp_pkg::*;

    localparam int NS = 4;
    localparam int DW = DWELL_SIM;
    localparam int CW = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NS-1:0]      req = '0;
    logic [NS*32-1:0]   data = '0;
    logic               nxt = 1'b0;
    logic               hld = 1'b0;
    logic [NS-1:0]      grant;
    logic               grant_valid;
    logic [3:0]         disp_src;
    logic [31:0]        disp_data;

    logic [31:0]        w [NS];

    always #5 clk = ~clk;

    disp_src_arbiter #(
        .NUM_SRC   (NS),
        .DWELL_CYC (DW),
        .CNT_W     (CW)
    ) dut (
        .fpga_clk    (clk),
        .fpga_rst    (rst_n),
        .src_req     (req),
        .src_data    (data),
        .next_pls    (nxt),
        .hold        (hld),
        .grant       (grant),
        .grant_valid (grant_valid),
        .disp_src    (disp_src),
        .disp_data   (disp_data)
    );

    typedef struct {
        logic [NS-1:0] g;
        logic          v;
        logic [3:0]    s;
        logic [31:0]   d;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: which source is on screen, how many cycles remain
    int          m_cur;
    int          m_last;
    int          m_left;
    bit          m_frozen;
    logic [31:0] m_data;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] tagw(int s, logic [31:0] x);
`ifdef DISP_SRC_TAG_EN
        return {4'(s), x[27:0]};
`else
        return x + 32'(s * 0);
`endif
    endfunction

    function automatic int next_after(int from, logic [NS-1:0] r);
        for (int k = 1; k <= NS; k++) begin
            int c;
            c = (from + k) % NS;
            if ((r & (NS'(1) << c)) != '0) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_cur = -1; m_last = NS - 1; m_left = 0; m_frozen = 1'b0; m_data = '0;
    endfunction

    function automatic void model_step(logic [NS-1:0] r, bit n, bit h);
        if (m_cur < 0) begin
            if (r != '0) begin
                m_cur  = next_after(m_last, r);
                m_last = m_cur;
                m_left = DW - 1;
            end
        end else if (m_frozen) begin
            if (!h) m_frozen = 1'b0;
        end else if (h) begin
            m_frozen = 1'b1;
        end else begin
            m_data = tagw(m_cur, w[m_cur]);
            if (m_left == 0 || n || (r & (NS'(1) << m_cur)) == '0) begin
                if (r == '0) begin
                    m_cur = -1; m_left = 0; m_data = '0;
                end else begin
                    m_cur  = next_after(m_cur, r);
                    m_last = m_cur;
                    m_left = DW - 1;
                end
            end else begin
                m_left--;
            end
        end
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic cyc(logic [NS-1:0] r, bit n, bit h);
        exp_t e;
        @(negedge clk);
        req = r; nxt = n; hld = h;
        for (int i = 0; i < NS; i++) data[i*32 +: 32] = w[i];
        model_step(r, n, h);
        e.g = (m_cur >= 0) ? (NS'(1) << m_cur) : '0;
        e.v = (m_cur >= 0);
        e.s = (m_cur >= 0) ? 4'(m_cur) : 4'd0;
        e.d = m_data;
        q.push_back(e);
    endtask

    // Directed check just after the next active edge
    task automatic post(string nm, logic [NS-1:0] g, logic [31:0] d, bit cd);
        @(posedge clk);
        #2;
        chk({nm, "_grant"}, 32'(grant), 32'(g));
        if (cd) chk({nm, "_data"}, disp_data, d);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic async_reset(string nm);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_grant"}, 32'(grant), 32'd0);
        chk({nm, "_rst_valid"}, 32'(grant_valid), 32'd0);
        chk({nm, "_rst_src"},   32'(disp_src), 32'd0);
        chk({nm, "_rst_data"},  disp_data, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented output against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_grant", 32'(grant), 32'(e.g));
                chk("sb_valid", 32'(grant_valid), 32'(e.v));
                chk("sb_src",   32'(disp_src), 32'(e.s));
                chk("sb_data",  disp_data, e.d);
            end
        end
    end

    logic [3:0] s1g [9];
    int         s1d [9];

    initial begin
        logic [NS-1:0] r;
        model_reset();
        for (int i = 0; i < NS; i++) w[i] = '0;
        s1g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                4'b0100, 4'b0100, 4'b0100, 4'b0001};
        s1d = '{-1, 0, 0, 0, 0, 2, 2, 2, 2};
        repeat (3) @(posedge clk);
        #2;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_data",  disp_data, 32'd0);
        rst_n = 1'b1;

        // Idle with no requests, hold has no effect
        cyc(4'b0000, 1'b0, 1'b1);
        post("idle", 4'b0000, 32'd0, 1'b1);

        // Scenario 1: alternate sources 0 and 2
        w[0] = 32'h11111111; w[2] = 32'h22222222;
        for (int k = 0; k < 9; k++) begin
            cyc(4'b0101, 1'b0, 1'b0);
            post("rr01", s1g[k], (s1d[k] < 0) ? 32'd0 : tagw(s1d[k], w[s1d[k]]), 1'b1);
        end
        async_reset("mid_show");

        // Scenario 3: next_pls coincides with counter expiry
        w[0] = $urandom; w[1] = 32'hAAAA0001; w[2] = 32'h2BCD0002; w[3] = $urandom;
        cyc(4'b0111, 1'b0, 1'b0);
        post("first_after_rst", 4'b0001, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'b0111, 1'b0, 1'b0);
        cyc(4'b0111, 1'b1, 1'b0);
        post("single_adv", 4'b0010, 32'd0, 1'b0);
        cyc(4'b0111, 1'b0, 1'b0);
        post("single_adv2", 4'b0010, tagw(1, 32'hAAAA0001), 1'b1);

        // Scenario 4: freeze while source 1 drops its request
        w[1] = 32'h5555BBBB;
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0101, 1'b1, 1'b1);
            post("hold_frozen", 4'b0010, tagw(1, 32'hAAAA0001), 1'b1);
        end
        cyc(4'b0101, 1'b0, 1'b0);
        post("hold_release", 4'b0010, tagw(1, 32'hAAAA0001), 1'b1);
        cyc(4'b0101, 1'b0, 1'b0);
        post("after_hold", 4'b0100, tagw(1, 32'h5555BBBB), 1'b1);
        cyc(4'b0101, 1'b0, 1'b0);
        post("tag_src2", 4'b0100, tagw(2, 32'h2BCD0002), 1'b1);

        // Scenario 5: all requests drop
        cyc(4'b0000, 1'b0, 1'b0);
        post("to_idle", 4'b0000, 32'd0, 1'b1);

        // Scenario 2: lone requester re-granted across expiries
        async_reset("pre_single");
        for (int k = 0; k < 14; k++) begin
            w[3] = $urandom;
            cyc(4'b1000, 1'b0, 1'b0);
            post("lone", 4'b1000, 32'd0, 1'b0);
        end

        // Randomised traffic checked only by the scoreboard
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NS; i++) w[i] = $urandom;
            r = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            cyc(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 99) == 0) async_reset("rand");
        end

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_src_arbiter.md
Name: disp_src_arbiter

Overview:
Time-shares the 8-digit seven-segment display between up to NUM_SRC 32-bit debug sources, for example reg19_data, debug_wb_pc and debug_wb_value. It sits between the CPU debug outputs and the display driver, and drives the driver's 32-bit data input. Sources are served round-robin, each for a fixed dwell time. A manual-advance pulse and a freeze input support board-level debugging.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
DWELL_CYC, 50000000, clock cycles each source is shown (minimum 2)
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYC

Ports:
fpga_clk  in  1  system clock
fpga_rst  in  1  asynchronous, active-low reset
src_req  in  NUM_SRC  per-source "wants display" level
src_data  in  NUM_SRC*32  flattened source words; source i occupies bits [32i+31:32i]
next_pls  in  1  one-cycle pulse: advance to the next requester now
hold  in  1  level: freeze the displayed value and the dwell timer
grant  out  NUM_SRC  one-hot mask of the source being shown; all-zero when idle
grant_valid  out  1  a source is currently granted
disp_src  out  4  index of the granted source
disp_data  out  32  word sent to the display driver

Behaviour:
- Clock and reset: one clock, fpga_clk. fpga_rst is asynchronous and active-low.
- Reset values: grant=0, grant_valid=0, disp_src=0, disp_data=0, state=IDLE, dwell counter=0, round-robin pointer=NUM_SRC-1 (so source 0 wins first).
- State IDLE:
  - If src_req==0, stay in IDLE with outputs at reset values.
  - Otherwise pick the round-robin winner (first requester after the pointer, wrapping).
  - Next edge: enter SHOW, set grant/disp_src/grant_valid, load counter with DWELL_CYC-1, update pointer to the winner.
- State SHOW:
  - disp_data <= src_data of the granted source every cycle (registered; 1-cycle latency from src_data).
  - Counter decrements by 1 per cycle.
- Re-arbitration trigger: counter==0, OR next_pls==1, OR the granted source's src_req==0.
  - On trigger, pick the next requester after the current one.
  - If the current source is the only requester, it is re-granted and the counter reloads.
  - If no source requests, go to IDLE; disp_data clears to 0 on that edge.
  - Counter expiry and next_pls in the same cycle cause a single advance, not two.
- State HOLD:
  - Entered from SHOW when hold==1.
  - disp_data, grant and counter are frozen. next_pls is ignored. src_req drops are ignored.
  - When hold falls, return to SHOW. A pending trigger (for example, the source has dropped its request) takes effect in the first SHOW cycle.
  - hold in IDLE has no effect.
- Grant switch latency: a new source appears on disp_data 1 cycle after the grant change.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
- Width rules: disp_src is zero-extended to 4 bits. Bits of src_req at index NUM_SRC and above do not exist.

Optional Feature:
DISP_SRC_TAG_EN
- Defined: disp_data[31:28] is replaced by disp_src, so the leftmost digit shows which source is displayed. Bits [27:0] are unchanged. When idle, the tag is 0.
- Undefined: disp_data is the full 32-bit source word.

Decomposition:
- Shared package disp_pkg holds:
  - state encoding IDLE/SHOW/HOLD (2-bit typedef)
  - default NUM_SRC and DWELL_CYC constants
  - DWELL_SIM=4 constant for benches
- One sub-module, disp_rr_pick: a combinational round-robin picker. Inputs are the request mask and the pointer; outputs are the one-hot winner, its index and an any-request flag. It is instantiated once.

Test Plan:
All scenarios use DWELL_CYC=4.
1. Reset, then src_req=4'b0101, src_data0=32'h11111111, src_data2=32'h22222222 -> grant=0001 first. disp_data=32'h11111111 one cycle later. After 4 cycles grant=0100 and disp_data=32'h22222222. Then back to 0001.
2. Single requester src_req=4'b1000 -> grant stays 1000 across repeated expiries; disp_data follows src_data3 with 1-cycle latency.
3. next_pls asserted in the same cycle the counter hits 0, with src_req=4'b0111 and source 0 granted -> exactly one advance, to source 1 (not source 2).
4. With source 1 granted, assert hold, drop src_req[1], change src_data1 -> disp_data and grant frozen. Release hold -> next requester granted in the following cycle.
5. Drop all requests in SHOW -> IDLE, grant=0, grant_valid=0, disp_data=0. Pull fpga_rst low mid-SHOW -> outputs go to 0 asynchronously, and the next grant is source 0.
6. With DISP_SRC_TAG_EN defined and source 2 granted with data 32'hABCDEF01 -> disp_data=32'h2BCDEF01.
